// File: rtl/gray_count_source_pkg.sv
// gray_pkg: shared width default, state type and
// binary-to-Gray helper for the Gray count source.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [15:0] bin2gray(
    input logic [15:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_count_source_if.sv
// Output stream bundle of the Gray count source:
// valid/ready handshake plus the count payload.
interface gray_count_source_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) ();

  logic             out_valid;
  logic             out_ready;
  logic             wrap;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] binary_out;

  modport master (
    output out_valid,
    output gray_out,
    output binary_out,
    output wrap,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  gray_out,
    input  binary_out,
    input  wrap,
    output out_ready
  );

endinterface

// File: rtl/gray_count_source_bin2gray.sv
// bin2gray_comb: combinational binary to reflected
// Gray conversion feeding the gray_out register.
module bin2gray_comb
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_count_source.sv
// Up/down counter streamed as binary+Gray beats.
// GRAY_STEP_CHECK_EN adds a sticky one-bit-step checker.
module gray_count_source
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  gray_count_source_if.master bus,
  output logic             err
);

  localparam logic [WIDTH-1:0] MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] step;
  logic             wrap_q;
  logic             wrap_d;
  logic             xfer;

  assign xfer = (state == RUN) && bus.out_ready;

  // Next count: load only while idle, step only on a transfer.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    step   = up_dn ? bin_q + WIDTH'(1)
                   : bin_q - WIDTH'(1);
    if (state == IDLE) begin
      if (load) bin_d = load_bin;
    end else if (bus.out_ready) begin
      bin_d  = step;
      wrap_d = up_dn ? (bin_q == MAX)
                     : (bin_q == '0);
    end
  end

  bin2gray_comb #(
    .WIDTH(WIDTH)
  ) u_b2g (
    .bin  (bin_d),
    .gray (gray_d)
  );

  // State and output registers; gray tracks binary in lockstep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      case (state)
        IDLE: if (en) state <= RUN;
        RUN:  if (xfer && !en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = (state == RUN);
  assign bus.binary_out = bin_q;
  assign bus.gray_out   = gray_q;
  assign bus.wrap       = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
  logic             chk_pend;
  logic [WIDTH-1:0] prev_gray;
  logic             err_q;

  // Compare each post-transfer code against the one it replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_pend  <= 1'b0;
      prev_gray <= '0;
      err_q     <= 1'b0;
    end else begin
      chk_pend <= xfer;
      if (xfer) prev_gray <= gray_q;
      if (chk_pend &&
          $countones(gray_q ^ prev_gray) != 1)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_count_source.sv
// Bench for gray_count_source: directed beats plus
// random stimulus against a behavioural count model.
module tb_gray_count_source;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_bin;
  logic         err;

  gray_count_source_if #(.WIDTH(W)) bus ();

  gray_count_source #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_bin (load_bin),
    .bus      (bus),
    .err      (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  int gtab [N];
  int gseq [17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12,
                    13, 15, 14, 10, 11, 9, 8, 0};

  int m_bin;
  bit m_valid;
  bit m_wrap;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // Reference: counter semantics with plain modular arithmetic.
  always @(posedge clk) begin
    if (rst) begin
      m_bin   = 0;
      m_valid = 0;
      m_wrap  = 0;
    end else if (!m_valid) begin
      m_wrap = 0;
      if (load) m_bin = int'(load_bin);
      if (en) m_valid = 1;
    end else if (bus.out_ready) begin
      m_wrap = up_dn ? (m_bin == N - 1) : (m_bin == 0);
      m_bin  = (m_bin + (up_dn ? 1 : N - 1)) % N;
      if (!en) m_valid = 0;
    end else begin
      m_wrap = 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(bus.out_valid), 32'(m_valid));
      check("binary", 32'(bus.binary_out), m_bin);
      check("gray", 32'(bus.gray_out), gtab[m_bin]);
      check("wrap", 32'(bus.wrap), 32'(m_wrap));
      check("err", 32'(err), 0);
    end
  end

  initial begin
    // Gray table built by reflection, independent of xor form.
    gtab[0] = 0;
    for (int k = 0; k < W; k++)
      for (int i = 0; i < (1 << k); i++)
        gtab[(1 << k) + i] = (1 << k) | gtab[(1 << k) - 1 - i];

    rst = 1'b1; en = 1'b0; up_dn = 1'b1;
    load = 1'b0; load_bin = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_bin", 32'(bus.binary_out), 0);
    check("rst_gray", 32'(bus.gray_out), 0);
    check("rst_err", 32'(err), 0);

    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("up_gray", 32'(bus.gray_out), gseq[i]);
      check("up_wrap", 32'(bus.wrap), 32'(i == 16));
    end

    repeat (5) @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_bin", 32'(bus.binary_out), 5);
      check("hold_gray", 32'(bus.gray_out), 7);
      check("hold_valid", 32'(bus.out_valid), 1);
    end

    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_load_bin", 32'(bus.binary_out), 9);
    load = 1'b1; load_bin = 4'd3;
    @(negedge clk);
    check("run_load_bin", 32'(bus.binary_out), 10);
    check("run_load_gray", 32'(bus.gray_out), 15);
    load = 1'b0;

    repeat (2) @(negedge clk);
    check("pre_rst_bin", 32'(bus.binary_out), 12);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_bin", 32'(bus.binary_out), 0);
    check("mid_rst_gray", 32'(bus.gray_out), 0);
    check("mid_rst_err", 32'(err), 0);

    rst = 1'b0; load = 1'b1; load_bin = '0;
    en = 1'b1; up_dn = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    check("ld_first_valid", 32'(bus.out_valid), 1);
    check("ld_first_bin", 32'(bus.binary_out), 0);
    check("ld_first_wrap", 32'(bus.wrap), 0);
    load = 1'b0;
    @(negedge clk);
    check("dn_wrap_bin", 32'(bus.binary_out), 15);
    check("dn_wrap_gray", 32'(bus.gray_out), 8);
    check("dn_wrap_pulse", 32'(bus.wrap), 1);
    @(negedge clk);
    check("dn_after_bin", 32'(bus.binary_out), 14);
    check("dn_after_wrap", 32'(bus.wrap), 0);

    up_dn = 1'b1;
    repeat (N) @(negedge clk);
    up_dn = 1'b0;
    repeat (N) @(negedge clk);

    repeat (3000) begin
      rst           = ($urandom_range(0, 63) == 0);
      en            = ($urandom_range(0, 9) < 8);
      up_dn         = 1'($urandom_range(0, 1));
      load          = ($urandom_range(0, 4) == 0);
      load_bin      = W'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
    end

`ifdef GRAY_STEP_CHECK_EN
    rst = 1'b0; en = 1'b1; load = 1'b0;
    up_dn = 1'b1; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    force dut.gray_q = ~bus.gray_out;
    @(negedge clk);
    release dut.gray_q;
    check("chk_err_set", 32'(err), 1);
    repeat (3) begin
      @(negedge clk);
      check("chk_err_sticky", 32'(err), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("chk_err_clr", 32'(err), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (4) @(negedge clk);
`endif

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
